// File: rtl/two_port_bus_arbiter_pkg.sv
// Shared types for the two-port result bus arbiter.
// State encoding, mux select encodings and default data width.
package two_port_bus_arbiter_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        OWN_ONE,
        OWN_TWO
    } state_t;

    localparam logic SEL_ONE = 1'b0;
    localparam logic SEL_TWO = 1'b1;

endpackage

// File: rtl/two_port_bus_arbiter_mux.sv
// 2:1 datapath mux driving the shared result bus.
// Select 0 passes requester one, select 1 passes requester two.
module sixteenMuxTwoToOne
    import two_port_bus_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] in_one,
    input  logic [WIDTH-1:0] in_two,
    input  logic             in_select,
    output logic [WIDTH-1:0] ou_result
);

    assign ou_result = (in_select == SEL_TWO) ? in_two : in_one;

endmodule

// File: rtl/two_port_bus_arbiter.sv
// Round-robin per-burst arbiter for the shared 16-bit result bus.
// Owns the mux select and cuts bursts at MAX_BURST beats.
module two_port_bus_arbiter
    import two_port_bus_arbiter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = 8
) (
    input  logic             in_clk,
    input  logic             in_reset_n,
    input  logic             in_one_valid,
    input  logic [WIDTH-1:0] in_one_data,
    input  logic             in_one_last,
    output logic             ou_one_ready,
    input  logic             in_two_valid,
    input  logic [WIDTH-1:0] in_two_data,
    input  logic             in_two_last,
    output logic             ou_two_ready,
    output logic             ou_valid,
    output logic [WIDTH-1:0] ou_result,
    input  logic             in_ready,
    output logic             ou_select,
    output logic             ou_busy,
    output logic             ou_preempt
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    state_t     state;
    logic       rr_last;
    logic [7:0] beat_cnt;
    logic [7:0] cnt_next;
    logic       owner_valid;
    logic       owner_last;
    logic       xfer;
    logic       at_max;
    logic       release_now;
    logic       cut;
    logic       grant_any;
    logic       grant_sel;

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        unique case (1'b1)
            (state == OWN_ONE): begin
                owner_valid = in_one_valid;
                owner_last  = in_one_last;
            end
            (state == OWN_TWO): begin
                owner_valid = in_two_valid;
                owner_last  = in_two_last;
            end
            default: ;
        endcase
    end

    assign cnt_next    = beat_cnt + 8'd1;
    assign xfer        = owner_valid & in_ready;
    assign at_max      = (cnt_next == MAX_CNT);
    assign release_now = xfer & (owner_last | at_max);
    assign cut         = xfer & at_max & ~owner_last;

    // Contention goes to whoever did not own the bus last.
    assign grant_any = in_one_valid | in_two_valid;
    assign grant_sel = (in_one_valid & in_two_valid) ? ~rr_last
                     : (in_two_valid ? SEL_TWO : SEL_ONE);

    assign ou_valid     = owner_valid;
    assign ou_one_ready = (state == OWN_ONE) & in_ready;
    assign ou_two_ready = (state == OWN_TWO) & in_ready;
    assign ou_busy      = (state != IDLE);

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state      <= IDLE;
            rr_last    <= SEL_TWO;
            beat_cnt   <= 8'd0;
            ou_select  <= SEL_ONE;
            ou_preempt <= 1'b0;
        end else begin
            ou_preempt <= cut;
            if ((state == IDLE) || release_now) begin
                beat_cnt <= 8'd0;
                if (grant_any) begin
                    state     <= (grant_sel == SEL_TWO) ? OWN_TWO : OWN_ONE;
                    rr_last   <= grant_sel;
                    ou_select <= grant_sel;
                end else begin
                    state <= IDLE;
                end
            end else if (xfer) begin
                beat_cnt <= cnt_next;
            end
        end
    end

    sixteenMuxTwoToOne #(
        .WIDTH(WIDTH)
    ) u_mux (
        .in_one    (in_one_data),
        .in_two    (in_two_data),
        .in_select (ou_select),
        .ou_result (ou_result)
    );

endmodule

// File: tb/tb_two_port_bus_arbiter.sv
// Scoreboard bench for two_port_bus_arbiter.
// Expected beat order comes from a burst/chunk-level round-robin model.
module tb_two_port_bus_arbiter;

    localparam int W  = 16;
    localparam int MB = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_one_valid, in_one_last, ou_one_ready;
    logic [W-1:0] in_one_data;
    logic         in_two_valid, in_two_last, ou_two_ready;
    logic [W-1:0] in_two_data;
    logic         ou_valid, in_ready, ou_select, ou_busy, ou_preempt;
    logic [W-1:0] ou_result;

    two_port_bus_arbiter #(
        .WIDTH(W),
        .MAX_BURST(MB)
    ) dut (
        .in_clk       (clk),
        .in_reset_n   (rst_n),
        .in_one_valid (in_one_valid),
        .in_one_data  (in_one_data),
        .in_one_last  (in_one_last),
        .ou_one_ready (ou_one_ready),
        .in_two_valid (in_two_valid),
        .in_two_data  (in_two_data),
        .in_two_last  (in_two_last),
        .ou_two_ready (ou_two_ready),
        .ou_valid     (ou_valid),
        .ou_result    (ou_result),
        .in_ready     (in_ready),
        .ou_select    (ou_select),
        .ou_busy      (ou_busy),
        .ou_preempt   (ou_preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        logic         src;
        logic [W-1:0] data;
        logic         pre;
    } exp_t;

    beat_t q1[$];
    beat_t q2[$];
    exp_t  expq[$];
    int    xfer_cyc[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    pre_cnt = 0;
    bit    mon_en = 0;
    bit    pre_exp = 0;
    int    ready_mode = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic drive();
        in_one_valid = (q1.size() != 0);
        in_one_data  = in_one_valid ? q1[0].data : '0;
        in_one_last  = in_one_valid ? q1[0].last : 1'b0;
        in_two_valid = (q2.size() != 0);
        in_two_data  = in_two_valid ? q2[0].data : '0;
        in_two_last  = in_two_valid ? q2[0].last : 1'b0;
    endtask

    // Split each requester's beats into grants, then alternate grants
    // while both still have work; a grant with no release stalls all.
    function automatic void build_exp();
        exp_t cc[2][$];
        bit   ee[2][$];
        int   idx[2];
        int   prev;
        int   pick;
        bit   done;
        for (int r = 0; r < 2; r++) begin
            int cnt = 0;
            int n = (r == 1) ? q2.size() : q1.size();
            for (int i = 0; i < n; i++) begin
                beat_t b;
                exp_t  x;
                b = (r == 1) ? q2[i] : q1[i];
                cnt++;
                x.src  = (r == 1);
                x.data = b.data;
                x.pre  = (cnt == MB) && !b.last;
                cc[r].push_back(x);
                ee[r].push_back(b.last || (cnt == MB));
                if (b.last || (cnt == MB)) cnt = 0;
            end
        end
        idx[0] = 0;
        idx[1] = 0;
        prev = 1;
        forever begin
            bit h0 = idx[0] < cc[0].size();
            bit h1 = idx[1] < cc[1].size();
            if (!h0 && !h1) break;
            pick = (h0 && h1) ? 1 - prev : (h1 ? 1 : 0);
            done = 0;
            while (idx[pick] < cc[pick].size() && !done) begin
                expq.push_back(cc[pick][idx[pick]]);
                done = ee[pick][idx[pick]];
                idx[pick]++;
            end
            if (!done) break;
            prev = pick;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("preempt", {31'd0, ou_preempt}, {31'd0, pre_exp});
            if (ou_preempt) pre_cnt++;
            pre_exp = 0;
            if (ou_busy && ou_select && ou_one_ready) begin
                chk("one_ready_stall", 32'd1, 32'd0);
            end
            if (ou_busy && !ou_select && ou_two_ready) begin
                chk("two_ready_stall", 32'd1, 32'd0);
            end
            if (ou_valid && in_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", {16'd0, ou_result}, 32'hdead);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("result", {16'd0, ou_result}, {16'd0, e.data});
                    chk("select", {31'd0, ou_select}, {31'd0, e.src});
                    chk("owner_ready",
                        {30'd0, ou_two_ready, ou_one_ready},
                        e.src ? 32'd2 : 32'd1);
                    pre_exp = e.pre;
                    xfer_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        bit h1;
        bit h2;
        forever begin
            @(negedge clk);
            h1 = in_one_valid && ou_one_ready;
            h2 = in_two_valid && ou_two_ready;
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (h1 && q1.size() != 0) void'(q1.pop_front());
                if (h2 && q2.size() != 0) void'(q2.pop_front());
            end
            case (ready_mode)
                1: in_ready = ($urandom_range(0, 3) != 0);
                2: in_ready = ~in_ready;
                default: in_ready = 1'b1;
            endcase
            drive();
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (expq.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (expq.size() != 0) chk(name, expq.size(), 0);
        repeat (3) @(posedge clk);
        #3;
    endtask

    task automatic reset_dut(input bit check);
        mon_en = 0;
        rst_n = 1'b0;
        #1;
        if (check) begin
            chk("rst_busy", {31'd0, ou_busy}, 0);
            chk("rst_valid", {31'd0, ou_valid}, 0);
            chk("rst_select", {31'd0, ou_select}, 0);
            chk("rst_preempt", {31'd0, ou_preempt}, 0);
            chk("rst_readies", {30'd0, ou_two_ready, ou_one_ready}, 0);
        end
        q1.delete();
        q2.delete();
        expq.delete();
        pre_exp = 0;
        drive();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        mon_en = 1;
    endtask

    task automatic push(input int r, input logic [W-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        if (r == 1) q2.push_back(b);
        else q1.push_back(b);
    endtask

    initial begin
        in_ready = 1'b1;
        drive();
        #12;
        chk("init_busy", {31'd0, ou_busy}, 0);
        chk("init_valid", {31'd0, ou_valid}, 0);
        chk("init_select", {31'd0, ou_select}, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        mon_en = 1;

        // lone single beat
        ready_mode = 0;
        push(0, 16'hAAAA, 1'b1);
        build_exp();
        drive();
        wait_done("timeout_single");
        reset_dut(0);

        // contention, single beats, no bubbles
        push(0, 16'hAAAA, 1'b1);
        push(0, 16'hAAAA, 1'b1);
        push(1, 16'h5555, 1'b1);
        push(1, 16'h5555, 1'b1);
        build_exp();
        xfer_cyc.delete();
        drive();
        wait_done("timeout_alt");
        chk("alt_count", xfer_cyc.size(), 4);
        if (xfer_cyc.size() == 4) chk("alt_span", xfer_cyc[3] - xfer_cyc[0], 3);
        reset_dut(0);

        // two owns a 3-beat burst while one waits, ready toggling
        ready_mode = 2;
        push(1, 16'hfff0, 1'b0);
        push(1, 16'h000f, 1'b0);
        push(1, 16'h1111, 1'b1);
        build_exp();
        drive();
        @(posedge clk);
        #3;
        push(0, 16'h1234, 1'b1);
        expq.push_back('{src: 1'b0, data: 16'h1234, pre: 1'b0});
        drive();
        wait_done("timeout_burst");
        reset_dut(0);

        // cut at MAX_BURST
        ready_mode = 1;
        for (int i = 0; i < 10; i++) push(0, W'(16'h0100 + i), 1'b0);
        push(1, 16'hbeef, 1'b0);
        push(1, 16'hcafe, 1'b1);
        build_exp();
        pre_cnt = 0;
        drive();
        wait_done("timeout_preempt");
        chk("preempt_pulses", pre_cnt, 1);
        reset_dut(0);

        // randomized burst mixes
        for (int s = 0; s < 8; s++) begin
            for (int r = 0; r < 2; r++) begin
                int nb = $urandom_range(0, 3);
                for (int b = 0; b < nb; b++) begin
                    int len = $urandom_range(1, 12);
                    for (int k = 0; k < len; k++) begin
                        push(r, W'($urandom), k == len - 1);
                    end
                end
            end
            build_exp();
            drive();
            wait_done("timeout_random");
            reset_dut(0);
        end

        // asynchronous reset mid-burst, then fresh contention
        for (int i = 0; i < 6; i++) push(1, W'(16'h2200 + i), i == 5);
        build_exp();
        drive();
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_busy", {31'd0, ou_busy}, 1);
        reset_dut(1);
        ready_mode = 0;
        push(0, 16'hAAAA, 1'b1);
        push(1, 16'h5555, 1'b1);
        build_exp();
        xfer_cyc.delete();
        drive();
        wait_done("timeout_post_rst");
        chk("post_rst_count", xfer_cyc.size(), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
